// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RMACK
    } i2c_state_t;

    localparam logic       I2C_ACK              = 1'b0;
    localparam logic       I2C_NACK             = 1'b1;
    localparam int         BITS_PER_BYTE        = 8;
    localparam logic [6:0] I2C_DEFAULT_DEV_ADDR = 7'h42;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers with one history stage; produces SCL edges and
// START/STOP conditions. Flops reset to 1 (idle bus) so reset release
// never fabricates a START.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;
    logic                   w_scl;
    logic                   w_sda;

    // Shift raw pad levels through the synchroniser chain and history flop.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_scl      = w_scl;
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_hist;
    assign o_scl_fall = ~w_scl & r_scl_hist;
    assign o_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
    assign o_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;

endmodule

// File: rtl/i2c_regfile_target.sv
// I2C target with byte-wide register file, auto-incrementing pointer and
// write strobe. Optional SCL-low bus timeout enabled by I2C_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for START
// ADDR      | shifting in address + R/W
// ADDR_ACK  | driving address ACK
// PTR       | shifting in register pointer
// PTR_ACK   | driving pointer ACK
// WDATA     | shifting in write data
// WDATA_ACK | driving data ACK
// RDATA     | driving read data bits
// RMACK     | sampling master ACK/NACK
module i2c_regfile_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR       = I2C_DEFAULT_DEV_ADDR,
    parameter int         NUM_REGS       = 8,
    parameter int         SYNC_STAGES    = 2,
    parameter int         TIMEOUT_CYCLES = 4096,
    localparam int        PW             = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [NUM_REGS*8-1:0] registers_packed,
    output logic                  wr_strobe,
    output logic [PW-1:0]         wr_index,
    output logic                  busy
);

    localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE);

    i2c_state_t            r_state;
    logic [3:0]            r_bit_cnt;
    logic [7:0]            r_shift;
    logic                  r_rw;
    logic [PW-1:0]         r_ptr;
    logic [NUM_REGS*8-1:0] r_regs;
    logic                  r_sda_oe;
    logic                  r_busy;
    logic                  r_wr_strobe;
    logic [PW-1:0]         r_wr_index;

    logic                  w_scl;
    logic                  w_sda;
    logic                  w_scl_rise;
    logic                  w_scl_fall;
    logic                  w_start;
    logic                  w_stop;
    logic                  w_timeout;
    logic [7:0]            w_cur_byte;
    logic [PW-1:0]         w_ptr_next;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_scl      (w_scl),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_cur_byte = r_regs[{r_ptr, 3'b000} +: 8];
    assign w_ptr_next = (r_ptr == PW'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;

`ifdef I2C_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;

    // Down-counter of SCL-low clocks while a transaction is open.
    always_ff @(posedge clock) begin
        if (reset || !r_busy || w_scl) begin
            r_to_cnt <= TW'(TIMEOUT_CYCLES - 1);
        end else if (r_to_cnt != '0) begin
            r_to_cnt <= r_to_cnt - 1'b1;
        end
    end

    assign w_timeout = r_busy & ~w_scl & (r_to_cnt == '0);
`else
    assign w_timeout = 1'b0;
`endif

    // Protocol FSM, register file writes and pointer management.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rw        <= 1'b0;
            r_ptr       <= '0;
            r_regs      <= '0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_index  <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_timeout) begin
                r_state  <= IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_state   <= ADDR;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state  <= IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ADDR, PTR: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else if (w_scl_fall && r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            if (r_state == ADDR) begin
                                if (r_shift[7:1] == DEV_ADDR) begin
                                    r_sda_oe <= 1'b1;
                                    r_busy   <= 1'b1;
                                    r_rw     <= r_shift[0];
                                    r_state  <= ADDR_ACK;
                                end else begin
                                    r_state <= IDLE;
                                end
                            end else if (r_shift < 8'(NUM_REGS)) begin
                                r_ptr    <= r_shift[PW-1:0];
                                r_sda_oe <= 1'b1;
                                r_state  <= PTR_ACK;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= '0;
                            if (r_rw) begin
                                r_sda_oe <= ~w_cur_byte[7];
                                r_shift  <= {w_cur_byte[6:0], 1'b0};
                                r_state  <= RDATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= PTR;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= '0;
                            r_state   <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == LAST_BIT - 1'b1) begin
                                r_regs[{r_ptr, 3'b000} +: 8] <= {r_shift[6:0], w_sda};
                                r_wr_strobe <= 1'b1;
                                r_wr_index  <= r_ptr;
                                r_ptr       <= w_ptr_next;
                            end
                        end else if (w_scl_fall && r_bit_cnt == LAST_BIT) begin
                            r_sda_oe <= 1'b1;
                            r_state  <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == LAST_BIT) begin
                                r_sda_oe <= 1'b0;
                                r_ptr    <= w_ptr_next;
                                r_state  <= RMACK;
                            end else begin
                                r_sda_oe <= ~r_shift[7];
                                r_shift  <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end
                    RMACK: begin
                        // Count value 9 marks "master ACKed, reload on the next fall".
                        if (w_scl_rise) begin
                            if (w_sda == I2C_NACK) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_bit_cnt <= LAST_BIT + 1'b1;
                            end
                        end else if (w_scl_fall && r_bit_cnt == LAST_BIT + 1'b1) begin
                            r_sda_oe  <= ~w_cur_byte[7];
                            r_shift   <= {w_cur_byte[6:0], 1'b0};
                            r_bit_cnt <= '0;
                            r_state   <= RDATA;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_oe           = r_sda_oe;
    assign registers_packed = r_regs;
    assign wr_strobe        = r_wr_strobe;
    assign wr_index         = r_wr_index;
    assign busy             = r_busy;

endmodule

// File: tb/tb_i2c_regfile_target.sv
// Directed bench for i2c_regfile_target: bit-banged I2C master with an
// open-drain SDA model. Covers the I2C_TIMEOUT_EN path when that macro is set.
module tb_i2c_regfile_target;

    logic        clock = 1'b0;
    logic        reset;
    logic        scl_m;
    logic        sda_m;
    logic        sda_oe;
    logic [63:0] registers_packed;
    logic        wr_strobe;
    logic [2:0]  wr_index;
    logic        busy;
    logic        sda_line;

    int errors = 0;
    int checks = 0;

    int         strobe_cnt = 0;
    logic [2:0] strobe_idx [32];
    int         oe_cycles = 0;
    logic [7:0] exp_regs [8];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clock = ~clock;

    i2c_regfile_target #(
        .DEV_ADDR       (7'h42),
        .NUM_REGS       (8),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .scl_in           (scl_m),
        .sda_in           (sda_line),
        .sda_oe           (sda_oe),
        .registers_packed (registers_packed),
        .wr_strobe        (wr_strobe),
        .wr_index         (wr_index),
        .busy             (busy)
    );

    always @(negedge clock) begin
        if (wr_strobe) begin
            if (strobe_cnt < 32) strobe_idx[strobe_cnt] <= wr_index;
            strobe_cnt <= strobe_cnt + 1;
        end
        if (sda_oe) oe_cycles <= oe_cycles + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] packed_exp();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = exp_regs[i];
        return v;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clks(6);
        scl_m = 1'b1; wait_clks(8);
        sda_m = 1'b0; wait_clks(8);
        scl_m = 1'b0; wait_clks(2);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clks(6);
        scl_m = 1'b1; wait_clks(8);
        sda_m = 1'b1; wait_clks(8);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clks(6);
        scl_m = 1'b1; wait_clks(8);
        scl_m = 1'b0; wait_clks(2);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        sda_m = 1'b1; wait_clks(6);
        scl_m = 1'b1; wait_clks(4);
        ack = (sda_line == 1'b0);
        wait_clks(4);
        scl_m = 1'b0; wait_clks(2);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_clks(6);
            scl_m = 1'b1; wait_clks(4);
            d[i] = sda_line;
            wait_clks(4);
            scl_m = 1'b0; wait_clks(2);
        end
        sda_m = mack; wait_clks(6);
        scl_m = 1'b1; wait_clks(8);
        scl_m = 1'b0; wait_clks(2);
        sda_m = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         sc;
        int         oc;

        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(5);

        check("reset_sda_oe", 64'(sda_oe), 64'd0);
        check("reset_regs", registers_packed, 64'd0);
        check("reset_wr_strobe", 64'(wr_strobe), 64'd0);
        check("reset_wr_index", 64'(wr_index), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // Write A5, 5A starting at register 3
        i2c_start();
        write_byte(8'h84, ack); check("w1_addr_ack", 64'(ack), 64'd1);
        check("w1_busy", 64'(busy), 64'd1);
        write_byte(8'h03, ack); check("w1_ptr_ack", 64'(ack), 64'd1);
        write_byte(8'hA5, ack); check("w1_d0_ack", 64'(ack), 64'd1);
        write_byte(8'h5A, ack); check("w1_d1_ack", 64'(ack), 64'd1);
        i2c_stop();
        exp_regs[3] = 8'hA5; exp_regs[4] = 8'h5A;
        check("w1_strobe_cnt", 64'(strobe_cnt), 64'd2);
        check("w1_strobe_idx0", 64'(strobe_idx[0]), 64'd3);
        check("w1_strobe_idx1", 64'(strobe_idx[1]), 64'd4);
        check("w1_busy_after_stop", 64'(busy), 64'd0);
        check("w1_regs", registers_packed, packed_exp());

        // Load 6, 7 and (wrapping) 0
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h06, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack);
        write_byte(8'h33, ack);
        i2c_stop();
        exp_regs[6] = 8'h11; exp_regs[7] = 8'h22; exp_regs[0] = 8'h33;
        check("wrap_strobe_idx", 64'(strobe_idx[4]), 64'd0);
        check("wrap_regs", registers_packed, packed_exp());

        // Pointer write then repeated-START read of 3 bytes
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h06, ack); check("rd_ptr_ack", 64'(ack), 64'd1);
        i2c_start();
        write_byte(8'h85, ack); check("rd_addr_ack", 64'(ack), 64'd1);
        read_byte(1'b0, rd); check("rd_byte0", 64'(rd), 64'h11);
        read_byte(1'b0, rd); check("rd_byte1", 64'(rd), 64'h22);
        read_byte(1'b1, rd); check("rd_byte2", 64'(rd), 64'h33);
        wait_clks(4);
        check("rd_sda_released", 64'(sda_oe), 64'd0);
        i2c_stop();

        // Address mismatch
        oc = oe_cycles;
        i2c_start();
        write_byte(8'hA0, ack); check("mis_ack", 64'(ack), 64'd0);
        write_byte(8'h03, ack);
        check("mis_oe_cycles", 64'(oe_cycles - oc), 64'd0);
        check("mis_busy", 64'(busy), 64'd0);
        i2c_stop();
        check("mis_regs", registers_packed, packed_exp());

        // Out-of-range pointer keeps the old pointer
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h02, ack);
        write_byte(8'h9C, ack);
        i2c_stop();
        exp_regs[2] = 8'h9C;
        sc = strobe_cnt;
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h08, ack); check("badptr_nack", 64'(ack), 64'd0);
        write_byte(8'h77, ack); check("badptr_data_nack", 64'(ack), 64'd0);
        i2c_stop();
        check("badptr_no_strobe", 64'(strobe_cnt - sc), 64'd0);
        check("badptr_regs", registers_packed, packed_exp());
        i2c_start();
        write_byte(8'h85, ack);
        read_byte(1'b1, rd); check("badptr_ptr_kept", 64'(rd), 64'hA5);
        i2c_stop();

        // Aborted write: 4 data bits then STOP
        sc = strobe_cnt;
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h05, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        check("abort_sda_oe", 64'(sda_oe), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_no_strobe", 64'(strobe_cnt - sc), 64'd0);
        check("abort_regs", registers_packed, packed_exp());

        // Reset during a read byte (reg3 = A5, second bit is 0 -> SDA pulled)
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h03, ack);
        i2c_start();
        write_byte(8'h85, ack);
        wait_clks(6);
        scl_m = 1'b1; wait_clks(8);
        scl_m = 1'b0;
        for (int i = 0; i < 12 && !sda_oe; i++) wait_clks(1);
        check("rst_mid_driving", 64'(sda_oe), 64'd1);
        reset = 1'b1;
        wait_clks(1);
        check("rst_mid_sda_oe", 64'(sda_oe), 64'd0);
        check("rst_mid_regs", registers_packed, 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
        sda_m = 1'b1; scl_m = 1'b1;
        wait_clks(10);

`ifdef I2C_TIMEOUT_EN
        // SCL stuck low after an ACKed address
        i2c_start();
        write_byte(8'h84, ack); check("to_addr_ack", 64'(ack), 64'd1);
        wait_clks(80);
        check("to_busy", 64'(busy), 64'd0);
        check("to_sda_oe", 64'(sda_oe), 64'd0);
        sda_m = 1'b1; scl_m = 1'b1;
        wait_clks(10);
        i2c_start();
        write_byte(8'h84, ack); check("to_re_addr_ack", 64'(ack), 64'd1);
        write_byte(8'h01, ack);
        write_byte(8'h3C, ack); check("to_re_data_ack", 64'(ack), 64'd1);
        i2c_stop();
        exp_regs[1] = 8'h3C;
        check("to_re_regs", registers_packed, packed_exp());
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
